// File: rtl/gmii_axis_packer.sv
// gmii_axis_packer: packs a GMII-style receive byte stream into TDATA_BYTES-wide
// AXI4-Stream beats. Lane 0 of every beat carries the header {node_id, eth_type}.
// Beats are queued in a first-word fall-through FIFO with registered outputs.
// A frame that meets a full FIFO is truncated and closed by a terminator beat.
// Optional feature macro: GMII_AXIS_STATS_EN adds frame_cnt/drop_cnt counters.
module gmii_axis_packer #(
    parameter int unsigned TDATA_BYTES = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned LVL_W       = 5
) (
    input  logic                      tx_clk_out,
    input  logic                      rst,
    input  logic                      s_dv,
    input  logic                      s_en,
    input  logic [7:0]                s_data,
    input  logic [3:0]                node_id,
    input  logic [3:0]                eth_type,
    output logic                      axis_tvalid,
    output logic [8*TDATA_BYTES-1:0]  axis_tdata,
    output logic [TDATA_BYTES-1:0]    axis_tkeep,
    output logic                      axis_tlast,
    output logic                      axis_tuser,
    input  logic                      axis_tready,
    output logic [LVL_W-1:0]          fifo_level,
    output logic                      overflow
`ifdef GMII_AXIS_STATS_EN
    ,
    output logic [15:0]               frame_cnt,
    output logic [15:0]               drop_cnt
`endif
);

    localparam int unsigned P  = TDATA_BYTES - 1;
    localparam int unsigned DW = 8 * TDATA_BYTES;
    localparam int unsigned BW = DW + TDATA_BYTES + 2;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = (TDATA_BYTES > 1) ? $clog2(TDATA_BYTES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DROP,
        ST_TERM
    } state_t;

    // Frame / staging state
    state_t          state_q;
    logic            dv_q;
    logic            act_q;
    logic [7:0]      hdr_q;
    logic [8*P-1:0]  stg_q;
    logic [CW-1:0]   cnt_q;
    logic            overflow_q;

    // FIFO state
    logic [BW-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [BW-1:0]    out_q, out_d;
    logic             tvalid_q, tvalid_d;

    // Combinational helpers
    logic             rise_c;
    logic             acc_c;
    logic             pop_c;
    logic             full_c;
    logic             can_push_c;
    logic             push_req_c;
    logic             push_c;
    logic [BW-1:0]    push_beat_c;
    logic [8*P-1:0]   stg_ins_c;
    logic [TDATA_BYTES-1:0] keep_c;
    logic [LVL_W-1:0] remain_c;

`ifdef GMII_AXIS_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;
`endif

    assign rise_c     = s_dv & ~dv_q;
    assign acc_c      = s_dv & s_en;
    assign pop_c      = tvalid_q & axis_tready;
    assign full_c     = (lvl_q == LVL_W'(FIFO_DEPTH));
    assign can_push_c = ~full_c | pop_c;
    assign push_c     = push_req_c & can_push_c;

    // Staging insert of the current byte and tkeep for the staged byte count
    always_comb begin
        stg_ins_c = stg_q;
        keep_c    = '0;
        for (int unsigned i = 0; i < P; i++) begin
            if (CW'(i) == cnt_q) begin
                stg_ins_c[8*i +: 8] = s_data;
            end
        end
        for (int unsigned i = 0; i < TDATA_BYTES; i++) begin
            keep_c[i] = (CW'(i) <= cnt_q);
        end
    end

    // Push request and beat payload {tuser, tlast, tkeep, tdata}
    always_comb begin
        push_req_c  = 1'b0;
        push_beat_c = '0;
        case (state_q)
            ST_FILL: begin
                if (!s_dv) begin
                    push_req_c  = 1'b1;
                    push_beat_c = {1'b0, 1'b1, keep_c, stg_q, hdr_q};
                end else if (acc_c && (cnt_q == CW'(P))) begin
                    push_req_c  = 1'b1;
                    push_beat_c = {1'b0, 1'b0, keep_c, stg_q, hdr_q};
                end
            end
            ST_TERM: begin
                push_req_c  = 1'b1;
                push_beat_c = {1'b1, 1'b1, TDATA_BYTES'(1), DW'(hdr_q)};
            end
            default: ;
        endcase
    end

    // Frame FSM: delimiting, packing into staging, drop and terminator handling
    always_ff @(posedge tx_clk_out or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dv_q       <= 1'b1;    // a frame active at release must not look like a rise
            act_q      <= 1'b0;
            hdr_q      <= '0;
            stg_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
`ifdef GMII_AXIS_STATS_EN
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
`endif
        end else begin
            dv_q       <= s_dv;
            overflow_q <= 1'b0;
            act_q      <= (state_q == ST_IDLE) && s_dv && (act_q || !dv_q);
`ifdef GMII_AXIS_STATS_EN
            if (push_c && push_beat_c[BW-2] && !push_beat_c[BW-1]) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (acc_c && (rise_c || act_q)) begin
                        state_q <= ST_FILL;
                        hdr_q   <= {node_id, eth_type};
                        stg_q   <= (8*P)'(s_data);
                        cnt_q   <= CW'(1);
                    end
                end
                ST_FILL: begin
                    if (!s_dv) begin
                        overflow_q <= ~push_c;
                        state_q    <= push_c ? ST_IDLE : ST_TERM;
`ifdef GMII_AXIS_STATS_EN
                        if (!push_c) drop_cnt_q <= drop_cnt_q + 16'd1;
`endif
                    end else if (acc_c) begin
                        if (cnt_q == CW'(P)) begin
                            if (push_c) begin
                                stg_q <= (8*P)'(s_data);
                                cnt_q <= CW'(1);
                            end else begin
                                state_q    <= ST_DROP;
                                overflow_q <= 1'b1;
`ifdef GMII_AXIS_STATS_EN
                                drop_cnt_q <= drop_cnt_q + 16'd1;
`endif
                            end
                        end else begin
                            stg_q <= stg_ins_c;
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_DROP: begin
                    if (!s_dv) state_q <= ST_TERM;
                end
                ST_TERM: begin
                    if (push_c) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO next state; head is bypassed from the push when the queue drains to empty
    always_comb begin
        lvl_d    = lvl_q + LVL_W'(push_c) - LVL_W'(pop_c);
        rd_ptr_d = rd_ptr_q + AW'(pop_c);
        wr_ptr_d = wr_ptr_q + AW'(push_c);
        remain_c = lvl_q - LVL_W'(pop_c);
        tvalid_d = (lvl_d != '0);
        out_d    = '0;
        if (tvalid_d) begin
            out_d = (remain_c == '0) ? push_beat_c : mem_q[rd_ptr_d];
        end
    end

    // FIFO storage write
    always_ff @(posedge tx_clk_out) begin
        if (push_c) mem_q[wr_ptr_q] <= push_beat_c;
    end

    // FIFO pointers, level and registered output beat
    always_ff @(posedge tx_clk_out or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            out_q    <= '0;
            tvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
            out_q    <= out_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign axis_tvalid = tvalid_q;
    assign axis_tdata  = out_q[DW-1:0];
    assign axis_tkeep  = out_q[DW +: TDATA_BYTES];
    assign axis_tlast  = out_q[BW-2];
    assign axis_tuser  = out_q[BW-1];
    assign fifo_level  = lvl_q;
    assign overflow    = overflow_q;

`ifdef GMII_AXIS_STATS_EN
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_gmii_axis_packer.sv
// Directed bench for gmii_axis_packer (TDATA_BYTES=8, FIFO_DEPTH=16).
module tb_gmii_axis_packer;

    logic        clk;
    logic        rst;
    logic        s_dv;
    logic        s_en;
    logic [7:0]  s_data;
    logic [3:0]  node_id;
    logic [3:0]  eth_type;
    logic        axis_tvalid;
    logic [63:0] axis_tdata;
    logic [7:0]  axis_tkeep;
    logic        axis_tlast;
    logic        axis_tuser;
    logic        axis_tready;
    logic [4:0]  fifo_level;
    logic        overflow;
`ifdef GMII_AXIS_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int ovf_n = 0;
    int max_lvl = 0;

    logic [63:0] qd [$];
    logic [7:0]  qk [$];
    logic        ql [$];
    logic        qu [$];

    gmii_axis_packer #(
        .TDATA_BYTES(8),
        .FIFO_DEPTH (16),
        .LVL_W      (5)
    ) dut (
        .tx_clk_out (clk),
        .rst        (rst),
        .s_dv       (s_dv),
        .s_en       (s_en),
        .s_data     (s_data),
        .node_id    (node_id),
        .eth_type   (eth_type),
        .axis_tvalid(axis_tvalid),
        .axis_tdata (axis_tdata),
        .axis_tkeep (axis_tkeep),
        .axis_tlast (axis_tlast),
        .axis_tuser (axis_tuser),
        .axis_tready(axis_tready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef GMII_AXIS_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat capture and overflow/level observation, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (axis_tvalid && axis_tready) begin
                qd.push_back(axis_tdata);
                qk.push_back(axis_tkeep);
                ql.push_back(axis_tlast);
                qu.push_back(axis_tuser);
            end
            if (overflow) ovf_n = ovf_n + 1;
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        qd.delete(); qk.delete(); ql.delete(); qu.delete();
    endtask

    task automatic send_frame(input int n, input logic [7:0] first);
        s_dv = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_en   = 1'b1;
            s_data = first + 8'(i);
            tick();
        end
        s_en   = 1'b0;
        s_data = 8'h00;
        s_dv   = 1'b0;
        tick();
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int c = 0; c < 300 && qd.size() < n; c++) tick();
        chk(tag, 64'(qd.size()), 64'(n));
    endtask

    task automatic chk_beat(input string tag, input logic [63:0] d, input logic [7:0] k,
                            input logic l, input logic u);
        if (qd.size() == 0) begin
            chk({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_data"}, qd.pop_front(), d);
            chk({tag, "_keep"}, 64'(qk.pop_front()), 64'(k));
            chk({tag, "_last"}, 64'(ql.pop_front()), 64'(l));
            chk({tag, "_user"}, 64'(qu.pop_front()), 64'(u));
        end
    endtask

    // Expected beat data: header 8'h35 in lane 0, n consecutive bytes from lane 1
    function automatic logic [63:0] exp_beat(input logic [7:0] first, input int n);
        logic [63:0] d;
        d = 64'h35;
        for (int k = 0; k < n; k++) d[8*(k+1) +: 8] = first + 8'(k);
        return d;
    endfunction

    initial begin
        rst = 1'b1; s_dv = 1'b0; s_en = 1'b0; s_data = 8'h00;
        node_id = 4'h3; eth_type = 4'h5; axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_tvalid", 64'(axis_tvalid), 64'd0);
        chk("rst_tdata",  axis_tdata, 64'd0);
        chk("rst_tkeep",  64'(axis_tkeep), 64'd0);
        chk("rst_tlast",  64'(axis_tlast), 64'd0);
        chk("rst_tuser",  64'(axis_tuser), 64'd0);
        chk("rst_level",  64'(fifo_level), 64'd0);
        chk("rst_ovf",    64'(overflow), 64'd0);
        rst = 1'b0;
        tick(); tick();

        // 14-byte frame: two full beats, second carries tlast
        clear_q();
        send_frame(14, 8'h01);
        wait_beats("f14_count", 2);
        chk_beat("f14_b0", 64'h0706050403020135, 8'hFF, 1'b0, 1'b0);
        chk_beat("f14_b1", 64'h0E0D0C0B0A090835, 8'hFF, 1'b1, 1'b0);

        // 10-byte frame: full beat then 3-byte tail
        clear_q();
        send_frame(10, 8'h11);
        wait_beats("f10_count", 2);
        chk_beat("f10_b0", 64'h1716151413121135, 8'hFF, 1'b0, 1'b0);
        chk_beat("f10_b1", 64'h000000001A191835, 8'h0F, 1'b1, 1'b0);

        // 1-byte frame
        clear_q();
        send_frame(1, 8'hA5);
        wait_beats("f1_count", 1);
        chk_beat("f1_b0", 64'h000000000000A535, 8'h03, 1'b1, 1'b0);

        // Empty frame, then strobes with s_dv low: no beats
        clear_q();
        s_dv = 1'b1; repeat (3) tick();
        s_dv = 1'b0; tick();
        s_en = 1'b1; s_data = 8'hEE; repeat (4) tick();
        s_en = 1'b0; s_data = 8'h00;
        repeat (20) tick();
        chk("empty_count", 64'(qd.size()), 64'd0);
        chk("empty_level", 64'(fifo_level), 64'd0);

        // 63-byte frame under stall: 9 beats queued, head held stable
        clear_q();
        max_lvl = 0; ovf_n = 0;
        axis_tready = 1'b0;
        send_frame(63, 8'h40);
        tick(); tick();
        chk("stall_level",  64'(fifo_level), 64'd9);
        chk("stall_tvalid", 64'(axis_tvalid), 64'd1);
        chk("stall_tdata",  axis_tdata, exp_beat(8'h40, 7));
        chk("stall_tkeep",  64'(axis_tkeep), 64'hFF);
        repeat (5) tick();
        chk("stall_tvalid2", 64'(axis_tvalid), 64'd1);
        chk("stall_tdata2",  axis_tdata, exp_beat(8'h40, 7));
        chk("stall_tlast2",  64'(axis_tlast), 64'd0);
        axis_tready = 1'b1;
        wait_beats("f63_count", 9);
        for (int k = 0; k < 9; k++)
            chk_beat($sformatf("f63_b%0d", k), exp_beat(8'h40 + 8'(7*k), 7), 8'hFF, (k == 8), 1'b0);
        chk("f63_maxlvl", 64'(max_lvl), 64'd9);
        chk("f63_ovf",    64'(ovf_n), 64'd0);
`ifdef GMII_AXIS_STATS_EN
        chk("frame_cnt_4", 64'(frame_cnt), 64'd4);
`endif

        // 200-byte frame under stall: overflow, 16 kept beats, terminator
        clear_q();
        ovf_n = 0;
        axis_tready = 1'b0;
        send_frame(200, 8'h00);
        repeat (3) tick();
        chk("ovf_pulses", 64'(ovf_n), 64'd1);
        chk("ovf_level",  64'(fifo_level), 64'd16);
        repeat (5) tick();
        chk("ovf_level_hold", 64'(fifo_level), 64'd16);
        axis_tready = 1'b1;
        wait_beats("ovf_count", 17);
        for (int k = 0; k < 16; k++)
            chk_beat($sformatf("ovf_b%0d", k), exp_beat(8'(7*k), 7), 8'hFF, 1'b0, 1'b0);
        chk_beat("ovf_term", 64'h35, 8'h01, 1'b1, 1'b1);
        repeat (5) tick();
        chk("ovf_extra", 64'(qd.size()), 64'd0);
        chk("ovf_pulses2", 64'(ovf_n), 64'd1);
`ifdef GMII_AXIS_STATS_EN
        chk("drop_cnt_1", 64'(drop_cnt), 64'd1);
`endif

        // Reset mid-frame with s_dv held high
        clear_q();
        s_dv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_en = 1'b1; s_data = 8'h81 + 8'(i); tick();
        end
        rst = 1'b1;
        #2;
        chk("mrst_tvalid", 64'(axis_tvalid), 64'd0);
        chk("mrst_tkeep",  64'(axis_tkeep), 64'd0);
        chk("mrst_level",  64'(fifo_level), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_data = 8'h86 + 8'(i); tick();
        end
        s_en = 1'b0; s_dv = 1'b0; s_data = 8'h00;
        repeat (20) tick();
        chk("mrst_ignored", 64'(qd.size()), 64'd0);
        send_frame(7, 8'h91);
        wait_beats("mrst_count", 1);
        chk_beat("mrst_b0", 64'h9796959493929135, 8'hFF, 1'b1, 1'b0);
`ifdef GMII_AXIS_STATS_EN
        chk("frame_cnt_1", 64'(frame_cnt), 64'd1);
        chk("drop_cnt_0",  64'(drop_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
